bit_serial_g_ctrl: RTL and testbench

//  Sequences one half_adder_subtractor slice, plus a carry/borrow flop, as a bit-serial

---
 rtl/bit_serial_g_ctrl_if.sv | 38 +++
 rtl/bit_serial_g_ctrl.sv | 128 ++++++++++++
 tb/tb_bit_serial_g_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_g_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_g_ctrl_if
//  Purpose  : Producer/consumer handshake bundle for the bit-serial polar
//             g-function unit (operand side and result side).
//  Revision : 1.0  initial release
// ============================================================================
interface bit_serial_g_ctrl_if #(
    parameter int W = 6
);
    // operand side (SC scheduler -> unit)
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   llr_a;
    logic [W-1:0]   llr_b;
    logic           u_sel;

    // result side (unit -> LLR write-back)
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     res;

    // status
    logic           busy;

    // master drives operands and accepts results
    modport master (
        output in_valid, llr_a, llr_b, u_sel, out_ready,
        input  in_ready, out_valid, res, busy
    );

    // slave is the g-function unit itself
    modport slave (
        input  in_valid, llr_a, llr_b, u_sel, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_serial_g_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serial_g_ctrl
//  Purpose  : Bit-serial polar-decoder g-function. One half-adder/subtractor
//             slice pair plus a carry/borrow flop computes res = b + a (u=0)
//             or res = b - a (u=1) over W+1 bits, LSB first, one bit/cycle.
//  Revision : 1.0  initial release
// ============================================================================
module bit_serial_g_ctrl #(
    parameter int W  = 6,
    parameter int CW = 3
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bit_serial_g_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // index of the last bit processed (the sign-extension bit)
    localparam logic [CW-1:0] c_last_bit = CW'(W);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_cb;          // carry (u=0) or borrow (u=1)
    logic [W:0]     r_a;
    logic [W:0]     r_b;
    logic           r_u;
    logic [W:0]     r_res;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic           w_ai;
    logic           w_bi;
    logic           w_d1;
    logic           w_c1;
    logic           w_s;
    logic           w_c2;
    logic           w_cb_next;
    logic           w_accept;

    // current bit of each operand sits at the LSB of its shift register
    assign w_ai = r_a[0];
    assign w_bi = r_b[0];

    // first stage: b (+/-) a; subtract borrows when minuend b is 0 and a is 1
    assign w_d1 = w_bi ^ w_ai;
    assign w_c1 = r_u ? (~w_bi & w_ai) : (w_bi & w_ai);

    // second stage: partial (+/-) incoming carry/borrow
    assign w_s  = w_d1 ^ r_cb;
    assign w_c2 = r_u ? (~w_d1 & r_cb) : (w_d1 & r_cb);

    assign w_cb_next = w_c1 | w_c2;

    assign w_accept  = bus.in_valid & r_in_ready;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.busy      = r_busy;

    // sequencer: accept operands, run W+1 serial bit steps, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cb        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_u         <= 1'b0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a         <= {bus.llr_a[W-1], bus.llr_a};
                        r_b         <= {bus.llr_b[W-1], bus.llr_b};
                        r_u         <= bus.u_sel;
                        r_cb        <= 1'b0;
                        r_cnt       <= '0;
                        r_res       <= '0;
                        r_state     <= S_RUN;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_res <= {w_s, r_res[W:1]};
                    r_a   <= {1'b0, r_a[W:1]};
                    r_b   <= {1'b0, r_b[W:1]};
                    r_cb  <= w_cb_next;
                    // the carry/borrow out of the sign bit is simply dropped
                    if (r_cnt == c_last_bit) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_g_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serial_g_ctrl
//  Purpose  : Self-checking bench for bit_serial_g_ctrl against an integer
//             arithmetic reference (b + a or b - a, kept to W+1 bits).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serial_g_ctrl;

    localparam int W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    bit_serial_g_ctrl_if #(.W(W)) bus ();

    bit_serial_g_ctrl #(.W(W), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    // reference: plain signed arithmetic, result kept to W+1 bits
    function automatic logic [W:0] ref_g(input int a, input int b, input logic u);
        int r;
        r = u ? (b - a) : (b + a);
        return r[W:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        logic [31:0] rv;
        rv = $urandom;
        bus.llr_a = rv[W-1:0];
        bus.llr_b = rv[2*W-1:W];
        bus.u_sel = rv[31];
    endtask

    function automatic int rnd_llr();
        return int'($urandom_range(0, 63)) - 32;
    endfunction

    // one complete transaction: accept, run (inputs scrambled), hold, take
    task automatic do_op(input int a, input int b, input logic u, input int hold,
                         input bit keep_valid, input string name);
        logic [W:0] exp;
        int n;
        exp = ref_g(a, b, u);

        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_idle: got %b want 1", name, bus.in_ready);
        end

        bus.llr_a    = W'(a);
        bus.llr_b    = W'(b);
        bus.u_sel    = u;
        bus.in_valid = 1'b1;
        tick();
        if (!keep_valid) bus.in_valid = 1'b0;

        n = 0;
        while (bus.out_valid !== 1'b1 && n <= W + 2) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s run_status: in_ready=%b busy=%b want 0/1", name, bus.in_ready, bus.busy);
            end
            scramble();
            tick();
            n++;
        end

        checks++;
        if (n != W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles want %0d", name, n, W + 1);
        end

        checks++;
        if (bus.res !== exp) begin
            errors++;
            $display("FAIL %s res: got %h want %h (a=%0d b=%0d u=%b)", name, bus.res, exp, a, b, u);
        end

        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_status: in_ready=%b busy=%b want 0/1", name, bus.in_ready, bus.busy);
        end

        for (int h = 0; h < hold; h++) begin
            scramble();
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.res !== exp) begin
                errors++;
                $display("FAIL %s backpressure: out_valid=%b res=%h want 1/%h", name, bus.out_valid, bus.res, exp);
            end
        end

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res !== exp) begin
            errors++;
            $display("FAIL %s after_take: out_valid=%b in_ready=%b busy=%b res=%h want 0/1/0/%h",
                     name, bus.out_valid, bus.in_ready, bus.busy, bus.res, exp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.res !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: res=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
                     bus.res, bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_add_sub();
        do_op(3, 5, 1'b0, 0, 1'b0, "add_5p3");
        do_op(3, 5, 1'b1, 0, 1'b0, "sub_5m3");
        do_op(5, 3, 1'b1, 0, 1'b0, "sub_3m5");
    endtask

    task automatic test_extremes();
        do_op(31, -32, 1'b1, 0, 1'b0, "ext_m32m31");
        do_op(31, 31, 1'b0, 0, 1'b0, "ext_31p31");
        do_op(-32, -32, 1'b0, 0, 1'b0, "ext_m32pm32");
        do_op(-32, 31, 1'b1, 0, 1'b0, "ext_31mm32");
    endtask

    task automatic test_backpressure();
        do_op(-7, 12, 1'b1, 5, 1'b0, "bp_hold5");
    endtask

    task automatic test_back_to_back();
        // in_valid held high throughout: next op is accepted only once IDLE returns
        for (int k = 0; k < 4; k++)
            do_op(rnd_llr(), rnd_llr(), 1'($urandom_range(0, 1)), 1, 1'b1, "b2b");
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++)
            do_op(rnd_llr(), rnd_llr(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, "rand");
    endtask

    task automatic test_reset_mid_run();
        bus.llr_a    = W'(3);
        bus.llr_b    = W'(5);
        bus.u_sel    = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.res !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: res=%h out_valid=%b busy=%b in_ready=%b want 0/0/0/1",
                     bus.res, bus.out_valid, bus.busy, bus.in_ready);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 1, 1'b0, 0, 1'b0, "post_reset");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.llr_a     = '0;
        bus.llr_b     = '0;
        bus.u_sel     = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_reset();

        test_add_sub();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
